rv32i_mem_responder: RTL

Memory responder on the far side of the rv32i core's instruction-fetch and data-memory ports. Holds one shared word-addressed array serving one instruction read, one data read and one data write per cycle. Zero-fills the array after reset, then accepts a program image over a valid/ready preload port while holding the core. Flags misaligned and out-of-range accesses.

---
 rtl/rv32i_mem_pkg.sv | 32 +++
 rtl/rv32i_mem_array.sv | 31 +++
 rtl/rv32i_mem_responder.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/rv32i_mem_pkg.sv
// Shared types and address helpers for the rv32i memory responder.
// Every port decodes its byte address through these helpers.
package rv32i_mem_pkg;

   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      ST_CLEAR,
      ST_LOAD,
      ST_RUN
   } state_t;

   // Compares against the word offset so a window that ends at 2^32 cannot wrap.
   function automatic logic addr_in_range(input logic [WORD_W-1:0] addr,
                                          input logic [WORD_W-1:0] base,
                                          input logic [WORD_W-1:0] depth_words);
      logic [WORD_W-1:0] offset;
      offset = addr - base;
      return (addr >= base) && ((offset >> 2) < depth_words);
   endfunction

   // Low two address bits are simply dropped, so misaligned accesses hit the containing word.
   function automatic logic [WORD_W-1:0] word_index(input logic [WORD_W-1:0] addr,
                                                    input logic [WORD_W-1:0] base);
      return (addr - base) >> 2;
   endfunction

   function automatic logic addr_misaligned(input logic [WORD_W-1:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/rv32i_mem_array.sv
// Word storage: two registered read ports and one write port.
// Reads are read-first against a same-cycle write.
module rv32i_mem_array
   import rv32i_mem_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic [AW-1:0]     rd_a_addr,
   output logic [WORD_W-1:0] rd_a_data,
   input  logic [AW-1:0]     rd_b_addr,
   output logic [WORD_W-1:0] rd_b_data,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [WORD_W-1:0] wr_data
);

   logic [WORD_W-1:0] mem [DEPTH];

   // NOTE: no reset on the storage; the top level zero-fills it word by word after reset.
   // NOTE: non-blocking assignments make a same-edge read return the old word.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_a_data <= mem[rd_a_addr];
      rd_b_data <= mem[rd_b_addr];
   end

endmodule

// File: rtl/rv32i_mem_responder.sv
// Memory responder for the rv32i core: clear/preload/run sequencing, shared
// word array, and sticky access-fault capture.
module rv32i_mem_responder
   import rv32i_mem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] instruction_address,
   output logic [31:0] instruction_data,
   input  logic [31:0] data_address,
   input  logic        data_write_enable,
   input  logic [31:0] data_write_data,
   output logic [31:0] data_read_data,
   input  logic        load_valid,
   output logic        load_ready,
   input  logic [31:0] load_addr,
   input  logic [31:0] load_data,
   input  logic        load_done,
   output logic        core_hold,
   output logic        fault,
   output logic [31:0] fault_addr
);

   localparam int                AW      = $clog2(DEPTH_WORDS);
   localparam logic [WORD_W-1:0] DEPTH_W = WORD_W'(DEPTH_WORDS);
   localparam logic [AW-1:0]     LAST_IX = AW'(DEPTH_WORDS - 1);

   state_t            state;
   logic [AW-1:0]     clr_cnt;
   logic              inst_ok_q, data_ok_q;
   logic [WORD_W-1:0] inst_raw, data_raw;

   logic              i_in, d_in, l_in;
   logic              i_fault, d_fault, l_fault, load_hs;
   logic              wr_en;
   logic [AW-1:0]     wr_addr;
   logic [WORD_W-1:0] wr_data;

   assign i_in = addr_in_range(instruction_address, BASE_ADDR, DEPTH_W);
   assign d_in = addr_in_range(data_address, BASE_ADDR, DEPTH_W);
   assign l_in = addr_in_range(load_addr, BASE_ADDR, DEPTH_W);

   assign load_hs = (state == ST_LOAD) && load_valid;

   // The core's fetch address is meaningless while it is held, so it only faults in RUN.
   assign d_fault = !d_in || addr_misaligned(data_address);
   assign i_fault = (state == ST_RUN) && (!i_in || addr_misaligned(instruction_address));
   assign l_fault = load_hs && (!l_in || addr_misaligned(load_addr));

   // Write-port mux: clear > preload > core.
   always_comb begin
      // NOTE: defaults first so every path assigns every output and no latch is inferred.
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      unique case (state)
         ST_CLEAR: begin
            wr_en   = 1'b1;
            wr_addr = clr_cnt;
         end
         ST_LOAD: begin
            wr_en   = load_hs && l_in;
            wr_addr = AW'(word_index(load_addr, BASE_ADDR));
            wr_data = load_data;
         end
         ST_RUN: begin
            wr_en   = data_write_enable && d_in;
            wr_addr = AW'(word_index(data_address, BASE_ADDR));
            wr_data = data_write_data;
         end
         default: ;
      endcase
   end

   rv32i_mem_array #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_array (
      .clk       (clk),
      .rd_a_addr (AW'(word_index(instruction_address, BASE_ADDR))),
      .rd_a_data (inst_raw),
      .rd_b_addr (AW'(word_index(data_address, BASE_ADDR))),
      .rd_b_data (data_raw),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_CLEAR;
         clr_cnt    <= '0;
         load_ready <= 1'b0;
         core_hold  <= 1'b1;
      end else begin
         unique case (state)
            ST_CLEAR: begin
               clr_cnt <= clr_cnt + 1'b1;
               if (clr_cnt == LAST_IX) begin
                  state      <= ST_LOAD;
                  load_ready <= 1'b1;
               end
            end
            ST_LOAD: begin
               if (load_done) begin
                  state      <= ST_RUN;
                  load_ready <= 1'b0;
                  core_hold  <= 1'b0;
               end
            end
            ST_RUN: ;
            default: state <= ST_CLEAR;
         endcase
      end
   end

   // Registered read qualifiers keep the outputs at zero through reset, CLEAR and LOAD.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         inst_ok_q <= 1'b0;
         data_ok_q <= 1'b0;
      end else begin
         inst_ok_q <= (state == ST_RUN) && i_in;
         data_ok_q <= (state == ST_RUN) && d_in;
      end
   end

   assign instruction_data = inst_ok_q ? inst_raw : '0;
   assign data_read_data   = data_ok_q ? data_raw : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fault      <= 1'b0;
         fault_addr <= '0;
      end else if (!fault && (d_fault || i_fault || l_fault)) begin
         fault      <= 1'b1;
         fault_addr <= d_fault ? data_address :
                       i_fault ? instruction_address : load_addr;
      end
   end

endmodule
